cla_bist_checker: RTL and testbench
===================================

Name: cla_bist_checker

Overview:
Hardware self-test engine for the 4-bit carry-lookahead adder. It drives every {Cin, B, A} combination into an external adder instance. It then samples that adder's Sum/Cout and compares each result against an internal behavioural sum. A mismatch count, the first failing vector and a pass/done summary are reported to the system. It sits beside the adder in bring-up and self-test builds, acting as the receiving and checking end of the adder's stimulus/response interface.

Parameters:
WIDTH, 4, operand width of the adder under test; vector space is 2^(2*WIDTH+1)
LATENCY, 0, pipeline cycles the adder under test adds between operand input and Sum/Cout output
ERRW, 16, width of the error counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that begins a run; ignored while busy=1
A_out  out  WIDTH  operand A to the adder under test
B_out  out  WIDTH  operand B to the adder under test
Cin_out  out  1  carry-in to the adder under test
Sum_in  in  WIDTH  Sum returned by the adder under test
Cout_in  in  1  Cout returned by the adder under test
busy  out  1  high from the cycle after start is accepted until done rises
done  out  1  high in DONE; held until the next accepted start or rst
pass  out  1  valid when done=1; 1 when err_count==0
err_count  out  ERRW  number of mismatching vectors; saturates at all-ones
fail_valid  out  1  set on the first mismatch of a run
fail_vec  out  2*WIDTH+1  {Cin,B,A} of the first mismatching vector; held until the next start

Behaviour:
- Vector register v[2*WIDTH:0] has the following field mapping:
  - A_out = v[WIDTH-1:0]
  - B_out = v[2*WIDTH-1:WIDTH]
  - Cin_out = v[2*WIDTH]
  - All drive outputs are registered from v.
- Reset values:
  - State returns to IDLE.
  - v, A_out, B_out, Cin_out, err_count and fail_vec are all 0.
  - busy, done, pass and fail_valid are all 0.
- Reset mid-run aborts immediately; there is no partial result.
- States are IDLE, SETTLE, CHECK and DONE.
- IDLE, on start:
  - v, err_count, fail_valid and fail_vec are cleared; done is cleared.
  - busy is set.
  - The next state is SETTLE if LATENCY>0, otherwise CHECK.
- SETTLE:
  - Counts LATENCY cycles with v held, then moves to CHECK.
- CHECK (exactly one cycle per vector):
  - expected = A_out + B_out + Cin_out, computed at WIDTH+1 bits with no truncation.
  - mismatch = ({Cout_in,Sum_in} != expected).
  - On mismatch:
    - err_count increments, unless it is already all-ones.
    - If fail_valid==0, then fail_vec<=v and fail_valid<=1.
  - If v is all-ones, the next state is DONE.
  - Otherwise v increments and the next state is SETTLE (LATENCY>0) or CHECK (LATENCY==0).
- DONE:
  - busy=0, done=1, pass=(err_count==0); the final CHECK's increment is included.
  - start re-launches a run exactly as from IDLE.
- start while busy is ignored, with no restart and no state change.
- Timing:
  - Each vector occupies LATENCY+1 cycles.
  - A run takes 2^(2*WIDTH+1)*(LATENCY+1) cycles from the first SETTLE/CHECK cycle.
  - done rises on the following cycle.
- Inputs X/Z: none are expected; the adder under test is synchronous to clk or combinational.

Test Plan:
1. Correct behavioural adder, WIDTH=4, LATENCY=0, start pulse at cycle 0 -> busy high for 512 cycles. done rises at cycle 513, pass=1, err_count=0, fail_valid=0. A_out/B_out/Cin_out step 0..511 in {Cin,B,A} order.
2. Adder with Sum[0] stuck at 0 -> err_count=256, fail_valid=1, fail_vec=9'h001 (A=1,B=0,Cin=0), pass=0.
3. Adder with Cout stuck at 0 -> err_count=256 (120 with Cin=0 plus 136 with Cin=1), fail_vec=9'h01F (A=15,B=1,Cin=0), pass=0.
4. LATENCY=2 with a 2-stage registered adder model -> 1536 busy cycles, pass=1. The same model run with LATENCY=0 -> pass=0 and err_count>0.
5. rst asserted at cycle 100 of a run -> the next cycle has all outputs at their reset values. A start pulse afterwards gives a full clean run ending in pass=1.
6. start pulsed again at cycle 50 of a run -> ignored, and done still rises at cycle 513. A start pulse in DONE -> done=0, err_count=0, fail_valid=0 on the next cycle, and a new run begins.

Source files
------------

// File: rtl/cla_bist_checker.sv
// Self-test engine for a WIDTH-bit adder: it sweeps every {Cin,B,A} vector,
// compares the returned {Cout,Sum} with the true sum and reports the result.
module cla_bist_checker #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 0,
  parameter int unsigned ERRW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [WIDTH-1:0]  A_out,
  output logic [WIDTH-1:0]  B_out,
  output logic              Cin_out,
  input  logic [WIDTH-1:0]  Sum_in,
  input  logic              Cout_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERRW-1:0]   err_count,
  output logic              fail_valid,
  output logic [2*WIDTH:0]  fail_vec
);

  localparam int unsigned VW = 2 * WIDTH + 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // With a combinational adder there is nothing to wait for between vectors.
  localparam logic [1:0] VEC_STATE = (LATENCY > 0) ? SETTLE : CHECK;

  logic [1:0]      state_q, state_d;
  logic [VW-1:0]   v_q, v_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            fv_q, fv_d;
  logic [VW-1:0]   fvec_q, fvec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [WIDTH:0]  expected;
  logic            mismatch;

  assign A_out   = v_q[WIDTH-1:0];
  assign B_out   = v_q[2*WIDTH-1:WIDTH];
  assign Cin_out = v_q[2*WIDTH];

  always_comb begin
    expected = {1'b0, A_out} + {1'b0, B_out} + {{WIDTH{1'b0}}, Cin_out};
    mismatch = ({Cout_in, Sum_in} != expected);
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          v_d     = '0;
          cnt_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = VEC_STATE;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != {ERRW{1'b1}}) begin
            err_d = err_q + ERRW'(1);
          end
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = v_q;
          end
        end
        if (v_q == {VW{1'b1}}) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          v_d     = v_q + VW'(1);
          state_d = VEC_STATE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q & (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_cla_bist_checker.sv
// Bench for cla_bist_checker: a combinational adder (LATENCY=0 DUT) and a 2-stage
// registered adder (LATENCY=2 DUT), with selectable faults and an exhaustive reference model.
module tb_cla_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start0 = 1'b0, start2 = 1'b0;
  int   mode = 0;
  logic use_pipe0 = 1'b0;
  logic sel2 = 1'b0;
  logic [8:0] f0 = '0, f1 = '0, f2 = '0, f3 = '0;

  int checks = 0;
  int failures = 0;

  logic [3:0]  a0, b0, s0_in, a2, b2;
  logic        c0, c2, co0_in;
  logic        busy0, done0, pass0, fv0, busy2, done2, pass2, fv2;
  logic [15:0] err0, err2;
  logic [8:0]  fvec0, fvec2;
  logic [4:0]  resp0c, resp2c, p0a, p0b, p2a, p2b, in0;

  // Adder under test; faults: 1 Sum[0] stuck 0, 2 Cout stuck 0, 3 Sum[0] flipped on listed vectors.
  function automatic logic [4:0] adder_resp(int m, logic [8:0] v, logic [8:0] x0, logic [8:0] x1,
                                            logic [8:0] x2, logic [8:0] x3);
    logic [4:0] s;
    s = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
    case (m)
      1: s[0] = 1'b0;
      2: s[4] = 1'b0;
      3: if (v == x0 || v == x1 || v == x2 || v == x3) s[0] = ~s[0];
      default: ;
    endcase
    return s;
  endfunction

  always_comb resp0c = adder_resp(mode, {c0, b0, a0}, f0, f1, f2, f3);
  always_comb resp2c = adder_resp(mode, {c2, b2, a2}, f0, f1, f2, f3);

  always_ff @(posedge clk) begin
    p0a <= resp0c;
    p0b <= p0a;
    p2a <= resp2c;
    p2b <= p2a;
  end

  assign in0 = use_pipe0 ? p0b : resp0c;
  assign s0_in = in0[3:0];
  assign co0_in = in0[4];

  cla_bist_checker #(.WIDTH(4), .LATENCY(0), .ERRW(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .A_out(a0), .B_out(b0), .Cin_out(c0), .Sum_in(s0_in), .Cout_in(co0_in),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_vec(fvec0)
  );

  cla_bist_checker #(.WIDTH(4), .LATENCY(2), .ERRW(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .A_out(a2), .B_out(b2), .Cin_out(c2), .Sum_in(p2b[3:0]), .Cout_in(p2b[4]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_vec(fvec2)
  );

  logic       busy_m, done_m;
  logic [8:0] vec_m;
  assign busy_m = sel2 ? busy2 : busy0;
  assign done_m = sel2 ? done2 : done0;
  assign vec_m  = sel2 ? {c2, b2, a2} : {c0, b0, a0};

  // Exhaustive model: count vectors where the adder's answer differs from true arithmetic.
  task automatic model(output int exp_err, output int exp_first);
    logic [4:0] r;
    exp_err = 0;
    exp_first = -1;
    for (int v = 0; v < 512; v++) begin
      r = adder_resp(mode, 9'(v), f0, f1, f2, f3);
      if (int'(r) != (v % 16) + ((v / 16) % 16) + (v / 256)) begin
        exp_err++;
        if (exp_first < 0) exp_first = v;
      end
    end
  endtask

  // Pulses start, then follows the run to done; cycle 1 is the first cycle after acceptance.
  task automatic do_run(input int restart_at, output int bcnt, output int dcyc, output int serr);
    int lat;
    int cyc;
    lat = sel2 ? 2 : 0;
    bcnt = 0;
    serr = 0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    if (sel2) start2 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    cyc = 1;
    while (!done_m && cyc < 4000) begin
      if (busy_m) begin
        bcnt++;
        if (vec_m !== 9'((bcnt - 1) / (lat + 1))) serr++;
      end
      if (sel2) start2 = (cyc == restart_at); else start0 = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start0 = 1'b0;
    start2 = 1'b0;
    dcyc = cyc;
    checks++;
    if (done_m !== 1'b1) begin
      failures++;
      $display("FAIL run_timeout: done=%b after %0d cycles, required 1", done_m, cyc);
    end
  endtask

  task automatic check_clean_run(input string name, input int restart_at);
    int bc, dc, se, lat;
    lat = sel2 ? 2 : 0;
    mode = 0;
    do_run(restart_at, bc, dc, se);
    checks += 5;
    if (bc !== 512 * (lat + 1)) begin
      failures++; $display("FAIL %s_busy_cycles: got %0d required %0d", name, bc, 512 * (lat + 1));
    end
    if (dc !== 512 * (lat + 1) + 1) begin
      failures++; $display("FAIL %s_done_cycle: got %0d required %0d", name, dc, 512 * (lat + 1) + 1);
    end
    if (se !== 0) begin
      failures++; $display("FAIL %s_vector_order: %0d out-of-order cycles, required 0", name, se);
    end
    if ((sel2 ? pass2 : pass0) !== 1'b1 || (sel2 ? err2 : err0) !== 16'd0) begin
      failures++;
      $display("FAIL %s_pass: pass=%b err=%0d required pass=1 err=0", name,
               sel2 ? pass2 : pass0, sel2 ? err2 : err0);
    end
    if ((sel2 ? fv2 : fv0) !== 1'b0) begin
      failures++; $display("FAIL %s_fail_valid: got %b required 0", name, sel2 ? fv2 : fv0);
    end
  endtask

  task automatic check_faulty_run(input string name, input int exp_err, input int exp_first);
    int bc, dc, se;
    do_run(-1, bc, dc, se);
    checks += 4;
    if (int'(err0) !== exp_err) begin
      failures++; $display("FAIL %s_err_count: got %0d required %0d", name, err0, exp_err);
    end
    if (fv0 !== (exp_err > 0)) begin
      failures++; $display("FAIL %s_fail_valid: got %b required %b", name, fv0, exp_err > 0);
    end
    if (exp_err > 0 && fvec0 !== 9'(exp_first)) begin
      failures++; $display("FAIL %s_fail_vec: got %h required %h", name, fvec0, 9'(exp_first));
    end
    if (pass0 !== (exp_err == 0)) begin
      failures++; $display("FAIL %s_pass: got %b required %b", name, pass0, exp_err == 0);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks += 2;
    if ({c0, b0, a0, busy0, done0, pass0, fv0} !== 13'd0 || err0 !== 16'd0 || fvec0 !== 9'd0) begin
      failures++;
      $display("FAIL %s_dut0: vec=%h busy=%b done=%b pass=%b fv=%b err=%0d fvec=%h required all 0",
               name, {c0, b0, a0}, busy0, done0, pass0, fv0, err0, fvec0);
    end
    if ({c2, b2, a2, busy2, done2, pass2, fv2} !== 13'd0 || err2 !== 16'd0 || fvec2 !== 9'd0) begin
      failures++;
      $display("FAIL %s_dut2: vec=%h busy=%b done=%b pass=%b fv=%b err=%0d fvec=%h required all 0",
               name, {c2, b2, a2}, busy2, done2, pass2, fv2, err2, fvec2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    sel2 = 1'b0;
    use_pipe0 = 1'b0;
    check_clean_run("clean_lat0", -1);
  endtask

  task automatic test_stuck_faults();
    sel2 = 1'b0;
    mode = 1;
    check_faulty_run("sum0_stuck", 256, 9'h001);
    mode = 2;
    check_faulty_run("cout_stuck", 256, 9'h01F);
  endtask

  task automatic test_random_faults();
    int e, f;
    sel2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f0 = 9'($urandom); f1 = 9'($urandom); f2 = 9'($urandom); f3 = 9'($urandom);
      mode = 3;
      model(e, f);
      check_faulty_run("random_fault", e, f);
    end
  endtask

  task automatic test_latency();
    int bc, dc, se;
    sel2 = 1'b1;
    check_clean_run("clean_lat2", -1);
    sel2 = 1'b0;
    use_pipe0 = 1'b1;
    mode = 0;
    do_run(-1, bc, dc, se);
    checks++;
    if (pass0 !== 1'b0 || err0 === 16'd0) begin
      failures++;
      $display("FAIL latency_mismatch: pass=%b err=%0d required pass=0 err>0", pass0, err0);
    end
    use_pipe0 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    sel2 = 1'b0;
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    n = $urandom_range(60, 400);
    repeat (n) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_run");
    rst = 1'b0;
    check_clean_run("after_reset", -1);
  endtask

  task automatic test_back_to_back();
    sel2 = 1'b0;
    check_clean_run("restart_busy", $urandom_range(20, 80));
    mode = 1;
    check_faulty_run("pre_restart", 256, 9'h001);
    mode = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if ({done0, err0, fv0, busy0} !== {1'b0, 16'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL restart_done: done=%b err=%0d fv=%b busy=%b required done=0 err=0 fv=0 busy=1",
               done0, err0, fv0, busy0);
    end
    // Let the relaunched run finish; a second clean run must then pass as well.
    repeat (520) @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || pass0 !== 1'b1) begin
      failures++;
      $display("FAIL restart_done_run: done=%b pass=%b required 1 1", done0, pass0);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck_faults();
    test_random_faults();
    test_latency();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
